// File: rtl/hwag_gen2_pkg.sv
// Shared types and helpers for the hwag_gen2 crank/cam angle generator.
// Holds the state encoding, width derivations and the period classification tests.
package hwag_pkg;

    typedef enum logic [1:0] {
        ST_STOP    = 2'd0,
        ST_SEARCH  = 2'd1,
        ST_CONFIRM = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    localparam int unsigned CALC_W = 32;
    typedef logic [CALC_W-1:0] calc_t;

    function automatic int unsigned tooth_width(input int unsigned teeth);
        return (teeth < 2) ? 1 : $clog2(teeth);
    endfunction

    // Sub-tooth counter must reach (MISSING+1) pitches' worth of steps across the gap.
    function automatic int unsigned sub_width(input int unsigned frac_w, input int unsigned missing);
        return frac_w + $clog2(missing + 1);
    endfunction

    localparam int unsigned TEETH_DEF   = 60;
    localparam int unsigned FRAC_W_DEF  = 6;
    localparam int unsigned TOOTH_W_DEF = tooth_width(TEETH_DEF);
    localparam int unsigned ANG_W_DEF   = TOOTH_W_DEF + FRAC_W_DEF;

    function automatic logic gap_test(input calc_t p0, input calc_t p1, input calc_t c);
        return (p0 < (c >> 1)) && (p0 < (p1 << 1));
    endfunction

    function automatic logic nom_test(input calc_t p0, input calc_t p1, input calc_t p2,
                                      input calc_t pmin, input calc_t pmax);
        return (pmin < p0) && (pmin < p1) && (pmin < p2) && (p0 < pmax);
    endfunction

endpackage

// File: rtl/hwag_gen2_interp.sv
// Sub-tooth interpolator: divides the last normal tooth period into 2^FRAC_W steps
// and counts them, saturating at the end of a normal pitch or of the whole gap.
module hwag_interp
    import hwag_pkg::*;
#(
    parameter int unsigned PCNT_W  = 24,
    parameter int unsigned FRAC_W  = 6,
    parameter int unsigned MISSING = 2,
    localparam int unsigned SUB_W  = sub_width(FRAC_W, MISSING)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              cap_edge,
    input  logic              in_gap,
    input  logic [PCNT_W-1:0] p0,
    output logic [SUB_W-1:0]  sub
);

    localparam logic [SUB_W-1:0] LIM_PITCH = SUB_W'((1 << FRAC_W) - 1);
    localparam logic [SUB_W-1:0] LIM_GAP   = SUB_W'((MISSING + 1) * (1 << FRAC_W) - 1);

    logic [PCNT_W-1:0] step;
    logic [PCNT_W-1:0] tmr_q, tmr_d;
    logic [SUB_W-1:0]  lim;
    logic [SUB_W-1:0]  sub_q, sub_d;

    always_comb begin
        step = p0 >> FRAC_W;
        if (step == '0) begin
            step = PCNT_W'(1);
        end
        lim   = in_gap ? LIM_GAP : LIM_PITCH;
        tmr_d = tmr_q;
        sub_d = sub_q;
        if (clr || cap_edge) begin
            tmr_d = '0;
            sub_d = '0;
        end else if ((tmr_q + PCNT_W'(1)) >= step) begin
            tmr_d = '0;
            if (sub_q < lim) begin
                sub_d = sub_q + SUB_W'(1);
            end
        end else begin
            tmr_d = tmr_q + PCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr_q <= '0;
            sub_q <= '0;
        end else begin
            tmr_q <= tmr_d;
            sub_q <= sub_d;
        end
    end

    assign sub = sub_q;

endmodule

// File: rtl/hwag_gen2.sv
// N-minus-M crank/cam angle generator: period measurement, gap search/confirm,
// tooth tracking, sub-tooth interpolated angle and cam phase.
module hwag_gen2
    import hwag_pkg::*;
#(
    parameter int unsigned TEETH    = 60,
    parameter int unsigned MISSING  = 2,
    parameter int unsigned PCNT_W   = 24,
    parameter int unsigned FRAC_W   = 6,
    parameter int unsigned PCNT_MIN = 256,
    parameter int unsigned PCNT_MAX = 24'h555555,
    localparam int unsigned TOOTH_W = tooth_width(TEETH),
    localparam int unsigned ANG_W   = TOOTH_W + FRAC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cap_edge,
    input  logic               cam_edge,
    input  logic               ena,
    output logic               sync,
    output logic               gap_point,
    output logic [TOOTH_W-1:0] tooth_num,
    output logic [ANG_W-1:0]   angle,
    output logic               cam_phase,
    output logic               err_gap_lost,
    output logic               err_gap_early,
    output logic               err_timeout
);

    localparam int unsigned SUB_W = sub_width(FRAC_W, MISSING);
    localparam logic [PCNT_W-1:0]  TMO        = PCNT_W'(2 * PCNT_MAX);
    localparam logic [TOOTH_W-1:0] LAST_TOOTH = TOOTH_W'(TEETH - MISSING - 1);

    state_e             state_q, state_d;
    logic [PCNT_W-1:0]  cnt_q, cnt_d;
    logic [PCNT_W-1:0]  p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
    logic [TOOTH_W-1:0] tooth_q, tooth_d;
    logic               gap_point_q, gap_point_d;
    logic               cam_q, cam_d;
    logic               err_lost_q, err_lost_d;
    logic               err_early_q, err_early_d;
    logic               err_tmo_q, err_tmo_d;

    logic               is_gap, is_nom, timeout, at_last;
    logic               interp_clr, in_gap;
    logic [SUB_W-1:0]   sub;

    always_comb begin
        is_gap  = gap_test(CALC_W'(p0_q), CALC_W'(p1_q), CALC_W'(cnt_q));
        is_nom  = nom_test(CALC_W'(p0_q), CALC_W'(p1_q), CALC_W'(p2_q),
                           CALC_W'(PCNT_MIN), CALC_W'(PCNT_MAX));
        timeout = (state_q != ST_STOP) && (cnt_q >= TMO);
        at_last = (tooth_q == LAST_TOOTH);

        state_d     = state_q;
        cnt_d       = cnt_q;
        p0_d        = p0_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        tooth_d     = tooth_q;
        gap_point_d = 1'b0;
        cam_d       = cam_q;
        err_lost_d  = err_lost_q;
        err_early_d = err_early_q;
        err_tmo_d   = err_tmo_q;

        if (!ena) begin
            state_d     = ST_STOP;
            cnt_d       = '0;
            p0_d        = '0;
            p1_d        = '0;
            p2_d        = '0;
            tooth_d     = '0;
            cam_d       = 1'b0;
            err_lost_d  = 1'b0;
            err_early_d = 1'b0;
            err_tmo_d   = 1'b0;
        end else if (timeout) begin
            state_d     = ST_STOP;
            cnt_d       = '0;
            p0_d        = '0;
            p1_d        = '0;
            p2_d        = '0;
            tooth_d     = '0;
            cam_d       = 1'b0;
            err_lost_d  = 1'b0;
            err_early_d = 1'b0;
            err_tmo_d   = 1'b1;
        end else if (state_q == ST_STOP) begin
            if (cap_edge) begin
                state_d = ST_SEARCH;
                cnt_d   = PCNT_W'(1);
            end
        end else begin
            cnt_d = cap_edge ? PCNT_W'(1) : cnt_q + PCNT_W'(1);
            // Gap periods never enter the history, so p0 stays a normal-tooth reference.
            if (cap_edge && !is_gap) begin
                p0_d = cnt_q;
                p1_d = p0_q;
                p2_d = p1_q;
            end
            if (cap_edge) begin
                if (state_q == ST_SEARCH) begin
                    if (is_gap && is_nom) begin
                        state_d = ST_CONFIRM;
                        tooth_d = '0;
                    end
                end else if (is_gap && at_last) begin
                    state_d     = ST_RUN;
                    tooth_d     = '0;
                    gap_point_d = 1'b1;
                end else if (is_gap || at_last) begin
                    state_d = ST_SEARCH;
                    tooth_d = '0;
                    if (state_q == ST_RUN) begin
                        err_early_d = err_early_q | is_gap;
                        err_lost_d  = err_lost_q | ~is_gap;
                    end
                end else begin
                    tooth_d = tooth_q + TOOTH_W'(1);
                end
            end
            if (cam_edge && (state_q == ST_RUN)) begin
                cam_d = 1'b1;
            end else if (gap_point_d) begin
                cam_d = ~cam_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_STOP;
            cnt_q       <= '0;
            p0_q        <= '0;
            p1_q        <= '0;
            p2_q        <= '0;
            tooth_q     <= '0;
            gap_point_q <= 1'b0;
            cam_q       <= 1'b0;
            err_lost_q  <= 1'b0;
            err_early_q <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p0_q        <= p0_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            tooth_q     <= tooth_d;
            gap_point_q <= gap_point_d;
            cam_q       <= cam_d;
            err_lost_q  <= err_lost_d;
            err_early_q <= err_early_d;
            err_tmo_q   <= err_tmo_d;
        end
    end

    // The last tooth before the gap interpolates across all missing pitches.
    assign in_gap     = (state_q == ST_RUN) && at_last;
    assign interp_clr = !ena || timeout || (state_q == ST_STOP);

    hwag_interp #(
        .PCNT_W  (PCNT_W),
        .FRAC_W  (FRAC_W),
        .MISSING (MISSING)
    ) u_interp (
        .clk      (clk),
        .rst      (rst),
        .clr      (interp_clr),
        .cap_edge (cap_edge),
        .in_gap   (in_gap),
        .p0       (p0_q),
        .sub      (sub)
    );

    assign sync          = (state_q == ST_RUN);
    assign gap_point     = gap_point_q;
    assign tooth_num     = tooth_q;
    assign angle         = sync ? ({tooth_q, {FRAC_W{1'b0}}} + ANG_W'(sub)) : '0;
    assign cam_phase     = cam_q;
    assign err_gap_lost  = err_lost_q;
    assign err_gap_early = err_early_q;
    assign err_timeout   = err_tmo_q;

endmodule

// File: tb/tb_hwag_gen2.sv
// Directed bench for hwag_gen2 on a 12-2 wheel, 320-clk tooth, FRAC_W=4 (20-clk steps),
// PCNT_MAX=2000 (timeout after 4000 clk without an edge).
module tb_hwag_gen2;

    localparam int unsigned P = 320;

    logic       clk = 1'b0;
    logic       rst;
    logic       cap_edge;
    logic       cam_edge;
    logic       ena;
    logic       sync;
    logic       gap_point;
    logic [3:0] tooth_num;
    logic [7:0] angle;
    logic       cam_phase;
    logic       err_gap_lost;
    logic       err_gap_early;
    logic       err_timeout;

    int nchk = 0;
    int nerr = 0;

    hwag_gen2 #(
        .TEETH    (12),
        .MISSING  (2),
        .PCNT_W   (16),
        .FRAC_W   (4),
        .PCNT_MIN (16),
        .PCNT_MAX (2000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cap_edge      (cap_edge),
        .cam_edge      (cam_edge),
        .ena           (ena),
        .sync          (sync),
        .gap_point     (gap_point),
        .tooth_num     (tooth_num),
        .angle         (angle),
        .cam_phase     (cam_phase),
        .err_gap_lost  (err_gap_lost),
        .err_gap_early (err_gap_early),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag, input logic [31:0] exp_tmo);
        chk({tag, "_sync"},  32'(sync), 0);
        chk({tag, "_gp"},    32'(gap_point), 0);
        chk({tag, "_tooth"}, 32'(tooth_num), 0);
        chk({tag, "_angle"}, 32'(angle), 0);
        chk({tag, "_cam"},   32'(cam_phase), 0);
        chk({tag, "_lost"},  32'(err_gap_lost), 0);
        chk({tag, "_early"}, 32'(err_gap_early), 0);
        chk({tag, "_tmo"},   32'(err_timeout), exp_tmo);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic edge_cap(input logic with_cam);
        cap_edge = 1'b1;
        cam_edge = with_cam;
        tick(1);
        cap_edge = 1'b0;
        cam_edge = 1'b0;
    endtask

    task automatic tooth(input int p);
        tick(p - 1);
        edge_cap(1'b0);
    endtask

    task automatic teeth(input int n, input int p);
        repeat (n) tooth(p);
    endtask

    task automatic sync_up();
        edge_cap(1'b0);
        teeth(5, P);
        tooth(3 * P);
        teeth(9, P);
        tooth(3 * P);
    endtask

    initial begin
        rst      = 1'b0;
        ena      = 1'b0;
        cap_edge = 1'b0;
        cam_edge = 1'b0;
        tick(3);
        chk_zero("reset", 0);
        rst = 1'b1;
        ena = 1'b1;
        tick(2);
        chk("stop_sync", 32'(sync), 0);

        // Acquisition: SEARCH -> CONFIRM on first gap, RUN on second
        edge_cap(1'b0);
        teeth(5, P);
        tooth(3 * P);
        chk("g1_sync", 32'(sync), 0);
        teeth(9, P);
        chk("confirm_tooth", 32'(tooth_num), 9);
        chk("confirm_sync", 32'(sync), 0);
        tooth(3 * P);
        chk("g2_sync", 32'(sync), 1);
        chk("g2_gp", 32'(gap_point), 1);
        chk("g2_tooth", 32'(tooth_num), 0);
        chk("g2_cam", 32'(cam_phase), 1);
        tick(1);
        chk("g2_gp_pulse", 32'(gap_point), 0);

        // Interpolation within tooth 0 (k counts clk after the cap edge)
        tick(159);
        chk("t0_mid_angle", 32'(angle), 8);
        tick(159);
        chk("t0_end_angle", 32'(angle), 15);
        edge_cap(1'b0);
        chk("t1_tooth", 32'(tooth_num), 1);
        chk("t1_angle", 32'(angle), 16);
        for (int i = 2; i <= 4; i++) begin
            tooth(P);
            chk("run_tooth", 32'(tooth_num), 32'(i));
        end
        tooth(P);
        tick(160);
        chk("t5_mid_angle", 32'(angle), 88);
        tick(170);
        chk("t5_sat_angle", 32'(angle), 95);
        tick(9);
        edge_cap(1'b0);
        chk("t6_tooth", 32'(tooth_num), 6);
        teeth(3, P);
        chk("t9_tooth", 32'(tooth_num), 9);
        tick(500);
        chk("gap_mid_angle", 32'(angle), 169);
        tick(480);
        chk("gap_sat_angle", 32'(angle), 191);
        tick(19);
        edge_cap(1'b0);
        chk("g3_gp", 32'(gap_point), 1);
        chk("g3_tooth", 32'(tooth_num), 0);
        chk("g3_angle", 32'(angle), 0);
        chk("g3_cam", 32'(cam_phase), 0);

        // Cam edge forces phase 1, next gap toggles back
        teeth(2, P);
        tick(50);
        cam_edge = 1'b1;
        tick(1);
        cam_edge = 1'b0;
        chk("cam_force", 32'(cam_phase), 1);
        tick(268);
        edge_cap(1'b0);
        teeth(6, P);
        tooth(3 * P);
        chk("g4_gp", 32'(gap_point), 1);
        chk("g4_cam", 32'(cam_phase), 0);

        // Cam edge coinciding with the gap edge wins over the toggle
        teeth(3, P);
        tick(10);
        cam_edge = 1'b1;
        tick(1);
        cam_edge = 1'b0;
        chk("cam_force2", 32'(cam_phase), 1);
        tick(P - 12);
        edge_cap(1'b0);
        teeth(5, P);
        tick(3 * P - 1);
        edge_cap(1'b1);
        chk("g5_gp", 32'(gap_point), 1);
        chk("g5_cam", 32'(cam_phase), 1);

        // Early gap at tooth 4, then resync over two clean gaps
        teeth(4, P);
        tooth(3 * P);
        chk("early_flag", 32'(err_gap_early), 1);
        chk("early_sync", 32'(sync), 0);
        chk("early_gp", 32'(gap_point), 0);
        chk("early_lost", 32'(err_gap_lost), 0);
        teeth(9, P);
        tooth(3 * P);
        chk("resync_g6_sync", 32'(sync), 0);
        teeth(9, P);
        tooth(3 * P);
        chk("resync_g7_sync", 32'(sync), 1);
        chk("resync_g7_gp", 32'(gap_point), 1);
        chk("resync_g7_cam", 32'(cam_phase), 0);
        chk("early_sticky", 32'(err_gap_early), 1);

        // Gap suppressed: normal tooth where the gap belongs
        teeth(9, P);
        chk("pre_lost_tooth", 32'(tooth_num), 9);
        chk("pre_lost_sync", 32'(sync), 1);
        tooth(P);
        chk("lost_flag", 32'(err_gap_lost), 1);
        chk("lost_sync", 32'(sync), 0);
        chk("lost_tooth", 32'(tooth_num), 0);

        // No edges: timeout after 2*PCNT_MAX clk
        tick(3990);
        chk("pre_timeout", 32'(err_timeout), 0);
        tick(15);
        chk_zero("timeout", 1);

        // ena low mid-RUN
        sync_up();
        chk("ena_run_sync", 32'(sync), 1);
        chk("ena_run_tmo", 32'(err_timeout), 1);
        chk("ena_run_cam", 32'(cam_phase), 1);
        tick(100);
        chk("ena_run_angle", 32'(angle), 5);
        ena = 1'b0;
        tick(1);
        ena = 1'b1;
        chk_zero("ena_low", 0);

        // Asynchronous reset mid-RUN, checked before any clock edge
        sync_up();
        chk("rst_run_sync", 32'(sync), 1);
        teeth(2, P);
        tick(100);
        chk("rst_run_angle", 32'(angle), 37);
        #3 rst = 1'b0;
        #1;
        chk_zero("async_rst", 0);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
